// File: rtl/orion_pkg.sv
// Shared types for the memory-game reader path.
// State encoding and default widths for seq_verifier.
package orion_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 4;

  typedef logic [DATA_W_DEF-1:0] digit_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ARMED,
    DONE
  } state_t;

endpackage

// File: rtl/seq_verifier.sv
// Reads the stored digit sequence back from RAM and checks
// each player entry against it, reporting pass/fail/progress.
module seq_verifier
  import orion_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] seqLen,
  input  logic              enterPulse,
  input  logic [DATA_W-1:0] userDigit,
  input  logic              timeout,
  input  logic [DATA_W-1:0] ramData,
  output logic [ADDR_W-1:0] ramAddr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] matchCount
);

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_idx1;
  logic [DATA_W-1:0] r_exp;
  logic [DATA_W-1:0] r_pdig;
  logic [DATA_W-1:0] w_dig;
  logic              r_pend;
  logic              r_pass;
  logic              r_fail;
  logic              w_enter;
  logic              w_hit;
  logic              w_last;
  logic              w_cap;

  // A held entry takes precedence over a live one in ARMED.
  assign w_enter = r_pend | enterPulse;
  assign w_dig   = r_pend ? r_pdig : userDigit;
  assign w_hit   = (w_dig == r_exp);
  assign w_idx1  = r_idx + ADDR_W'(1);
  assign w_last  = (w_idx1 == r_len);
  assign w_cap   = enterPulse && !r_pend &&
                   ((r_state == FETCH) || (r_state == LOAD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_next = FETCH;
      end
      FETCH: begin
        if (timeout) w_next = DONE;
        else if (r_len == '0) w_next = DONE;
        else w_next = LOAD;
      end
      LOAD: begin
        if (timeout) w_next = DONE;
        else w_next = ARMED;
      end
      ARMED: begin
        if (timeout) w_next = DONE;
        else if (w_enter) begin
          if (!w_hit || w_last) w_next = DONE;
          else w_next = FETCH;
        end
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len  <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_exp  <= '0;
      r_pdig <= '0;
      r_pend <= 1'b0;
      r_pass <= 1'b0;
      r_fail <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_idx  <= '0;
            r_len  <= seqLen;
            r_cnt  <= '0;
            r_pend <= 1'b0;
            r_pass <= 1'b0;
            r_fail <= 1'b0;
          end
        end
        FETCH: begin
          if (timeout) r_fail <= 1'b1;
          else if (r_len == '0) r_pass <= 1'b1;
        end
        LOAD: begin
          r_exp <= ramData;
          if (timeout) r_fail <= 1'b1;
        end
        ARMED: begin
          r_pend <= 1'b0;
          if (timeout) begin
            r_fail <= 1'b1;
          end else if (w_enter) begin
            if (w_hit) begin
              r_cnt <= w_idx1;
              if (w_last) r_pass <= 1'b1;
              else r_idx <= w_idx1;
            end else begin
              r_fail <= 1'b1;
            end
          end
        end
        default: ;
      endcase
      // Only one early entry is held; later ones are dropped.
      if (w_cap) begin
        r_pend <= 1'b1;
        r_pdig <= userDigit;
      end
    end
  end

  assign ramAddr    = r_idx;
  assign busy       = (r_state == FETCH) ||
                      (r_state == LOAD)  ||
                      (r_state == ARMED);
  assign done       = (r_state == DONE);
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign matchCount = r_cnt;

endmodule

// File: doc/seq_verifier.md
# seq_verifier

Reads back the digit sequence the sequencer wrote into the sequence RAM and checks the player's entries against it, one digit per Enter press. Sits beside the game controller: it drives the RAM read address, consumes button-shaped Enter pulses and the 4-bit player digit, and reports pass/fail plus progress for scoring and display. It is the reader for the sequencer/RAM writer path.

## Interface
- ADDR_W, 5, RAM address width (sequence length up to 2^ADDR_W − 1 = 31)
- DATA_W, 4, digit width
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begin verifying a sequence
- seqLen  in  ADDR_W  number of digits to verify, sampled on start
- enterPulse  in  1  one-cycle pulse from buttonShaper; player submits a digit
- userDigit  in  DATA_W  player digit, sampled with enterPulse
- timeout  in  1  round timer expired (level)
- ramData  in  DATA_W  RAM read data, valid one cycle after ramAddr
- ramAddr  out  ADDR_W  RAM read address
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of round
- pass  out  1  round succeeded; held until next accepted start
- fail  out  1  round failed; held until next accepted start
- matchCount  out  ADDR_W  digits matched so far this round

## Operation
- States: IDLE, FETCH, LOAD, ARMED, DONE.
- IDLE: start → FETCH; idx←0, ramAddr←0, latch seqLen, clear pass/fail/matchCount/pending. If latched seqLen = 0 → DONE with pass.
- FETCH: ramAddr = idx presented to RAM; → LOAD.
- LOAD: expected←ramData; → ARMED.
- ARMED: on enterPulse (or pending set), compare userDigit (or pendingDigit) to expected.
  - Match: matchCount←idx+1. If idx+1 = seqLen → DONE, pass←1; else idx←idx+1, ramAddr←idx+1, → FETCH.
  - Mismatch: → DONE, fail←1, matchCount holds idx.
- Pending entry: enterPulse arriving in FETCH or LOAD is stored in a one-deep pending register (flag + digit) and consumed on entry to ARMED. A second enterPulse while pending is set is dropped.
- timeout high in FETCH, LOAD or ARMED → DONE, fail←1.
- DONE: done=1 for one cycle, busy=0; → IDLE.
- start outside IDLE ignored. enterPulse in IDLE/DONE ignored.
- Arithmetic: idx and matchCount unsigned ADDR_W, never wrap (bounded by seqLen ≤ 31).

## Timing
- Reset values: ramAddr=0, busy=0, done=0, pass=0, fail=0, matchCount=0, state=IDLE, pending clear. rst mid-round returns to IDLE immediately; no done pulse.
- start at cycle T: FETCH at T+1 (busy=1), LOAD T+2, ARMED T+3.
- Non-final match, enter at E (ARMED): FETCH E+1, LOAD E+2, ARMED E+3; matchCount updates at E+1.
- Final match or mismatch at E: done=1 and pass/fail valid at E+1; IDLE at E+2.
- Pending enter consumed in the first ARMED cycle; result follows the same latency as a live enter.
- Simultaneous timeout and enterPulse in ARMED: timeout wins, fail.
- Simultaneous rst and anything: rst wins.
- RAM latency is exactly one cycle; ramAddr is stable throughout FETCH and LOAD.

## Structure
- Shared package orion_pkg: state enum (IDLE, FETCH, LOAD, ARMED, DONE), ADDR_W/DATA_W defaults, digit type.
- Single module; no sub-module needed. The pending-entry register stays inline.

## Test plan
- seqLen=3, RAM={4,7,1}, enters 4,7,1 spaced 5 cycles → pass=1, done pulse one cycle after third enter, matchCount=3.
- seqLen=3, RAM={4,7,1}, enters 4,9 → fail=1 at cycle after second enter, matchCount=1, no further RAM reads.
- seqLen=0, start → done and pass at T+2, ramAddr stays 0.
- seqLen=2, RAM={5,5}, enter 5 at ARMED then enter 5 one cycle later (lands in FETCH) → pending consumed, pass=1. Third enter in LOAD dropped.
- seqLen=4, two matches, then timeout together with a correct enter → fail=1, matchCount=2.
- rst asserted in LOAD mid-round → all outputs 0 that cycle. Next start with seqLen=1, RAM[0]=8, enter 8 → pass.
